// File: rtl/bs_pkg.sv
// Shared boundary-scan definitions: per-cell operation encoding used by the
// chain register and by the TAP-side decode.
package bs_pkg;

  typedef enum logic [1:0] {
    OP_HOLD    = 2'd0,
    OP_CAPTURE = 2'd1,
    OP_SHIFT   = 2'd2
  } cell_op_e;

endpackage : bs_pkg

// File: rtl/bs_cell.sv
// Single boundary-scan cell: capture/shift flop, update flop and the
// functional/test output select.
module bs_cell
  import bs_pkg::*;
#(
  parameter logic UPD_INIT = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  input  cell_op_e op,
  input  logic     upd,
  input  logic     mode,
  input  logic     si,
  input  logic     pi,
  output logic     so,
  output logic     po
);

  logic shift_q, shift_d;
  logic upd_q, upd_d;

  // The update flop samples the pre-edge shift value, so update may coincide
  // with a capture or shift on the same edge.
  always_comb begin
    shift_d = shift_q;
    case (op)
      OP_CAPTURE: shift_d = pi;
      OP_SHIFT:   shift_d = si;
      default:    shift_d = shift_q;
    endcase
    upd_d = upd ? shift_q : upd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= 1'b0;
      upd_q   <= UPD_INIT;
    end else begin
      shift_q <= shift_d;
      upd_q   <= upd_d;
    end
  end

  assign so = shift_q;
  assign po = mode ? upd_q : pi;

endmodule : bs_cell

// File: rtl/bs_chain_reg.sv
// Boundary-scan data register: WIDTH chained scan cells plus strobe decode,
// saturating shift counter and illegal-strobe detection.
module bs_chain_reg
  import bs_pkg::*;
#(
  parameter int                WIDTH    = 8,
  parameter logic [WIDTH-1:0]  UPD_INIT = '0,
  localparam int               CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             mode,
  input  logic             tdi,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             tdo,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             shift_full,
  output logic             ctrl_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  cell_op_e         cell_op;
  logic [WIDTH-1:0] so;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ctrl_err_q, ctrl_err_d;

  // Capture wins over shift when both are strobed.
  always_comb begin
    cell_op = OP_HOLD;
    if (capture_dr) begin
      cell_op = OP_CAPTURE;
    end else if (shift_dr) begin
      cell_op = OP_SHIFT;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic si_w;
      if (gi == WIDTH - 1) begin : g_head
        assign si_w = tdi;
      end else begin : g_body
        assign si_w = so[gi+1];
      end

      bs_cell #(
        .UPD_INIT(UPD_INIT[gi])
      ) u_cell (
        .clk (clk),
        .rst (rst),
        .op  (cell_op),
        .upd (update_dr),
        .mode(mode),
        .si  (si_w),
        .pi  (par_in[gi]),
        .so  (so[gi]),
        .po  (par_out[gi])
      );
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (capture_dr) begin
      cnt_d = '0;
    end else if (shift_dr && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    ctrl_err_d = capture_dr & (shift_dr | update_dr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ctrl_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ctrl_err_q <= ctrl_err_d;
    end
  end

  assign tdo        = so[0];
  assign shift_cnt  = cnt_q;
  assign shift_full = (cnt_q == CNT_MAX);
  assign ctrl_err   = ctrl_err_q;

endmodule : bs_chain_reg

// File: tb/tb_bs_chain_reg.sv
// Directed bench for bs_chain_reg (WIDTH=8): vector table plus short
// hand-written sequences for reset-mid-shift and update-with-shift.
module tb_bs_chain_reg;

  logic       clk = 1'b0;
  logic       rst, capture_dr, shift_dr, update_dr, mode, tdi;
  logic [7:0] par_in, par_out;
  logic       tdo, shift_full, ctrl_err;
  logic [3:0] shift_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  bs_chain_reg #(
    .WIDTH   (8),
    .UPD_INIT(8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .capture_dr(capture_dr),
    .shift_dr  (shift_dr),
    .update_dr (update_dr),
    .mode      (mode),
    .tdi       (tdi),
    .par_in    (par_in),
    .par_out   (par_out),
    .tdo       (tdo),
    .shift_cnt (shift_cnt),
    .shift_full(shift_full),
    .ctrl_err  (ctrl_err)
  );

  typedef struct {
    logic       r;
    logic [2:0] strb;   // {capture, shift, update}
    logic       m;
    logic       t;
    logic [7:0] pin;
    logic [7:0] e_po;
    logic       e_tdo;
    logic [3:0] e_cnt;
    logic       e_full;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [2:0] strb, input logic m,
                              input logic t, input logic [7:0] pin, input logic [7:0] e_po,
                              input logic e_tdo, input logic [3:0] e_cnt, input logic e_full,
                              input logic e_err);
    vec_t v;
    v.r = r; v.strb = strb; v.m = m; v.t = t; v.pin = pin;
    v.e_po = e_po; v.e_tdo = e_tdo; v.e_cnt = e_cnt; v.e_full = e_full; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [2:0] strb, input logic m,
                       input logic t, input logic [7:0] pin);
    rst        = r;
    capture_dr = strb[2];
    shift_dr   = strb[1];
    update_dr  = strb[0];
    mode       = m;
    tdi        = t;
    par_in     = pin;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] e_po, input logic e_tdo,
                       input logic [3:0] e_cnt, input logic e_full, input logic e_err);
    n_total++;
    if (par_out === e_po && tdo === e_tdo && shift_cnt === e_cnt &&
        shift_full === e_full && ctrl_err === e_err) begin
      n_pass++;
      $display("ok   %s: po=%h tdo=%b cnt=%0d full=%b err=%b",
               name, par_out, tdo, shift_cnt, shift_full, ctrl_err);
    end else begin
      $display("FAIL %s: got po=%h tdo=%b cnt=%0d full=%b err=%b, want po=%h tdo=%b cnt=%0d full=%b err=%b",
               name, par_out, tdo, shift_cnt, shift_full, ctrl_err,
               e_po, e_tdo, e_cnt, e_full, e_err);
    end
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] v5a;
    a5  = 8'hA5;
    v5a = 8'h5A;

    // reset and functional pass-through
    vecs.push_back(mk(1, 3'b000, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 8'h3C, 8'h3C, 0, 0, 0, 0));
    // capture A5 then shift out: tdo = bit k after k shifts
    vecs.push_back(mk(0, 3'b100, 0, 0, 8'hA5, 8'hA5, 1, 0, 0, 0));
    for (int k = 1; k <= 8; k++) begin
      vecs.push_back(mk(0, 3'b010, 0, 0, 8'hA5, 8'hA5, (k < 8) ? a5[k] : 1'b0,
                        4'(k), (k == 8), 0));
    end
    vecs.push_back(mk(0, 3'b010, 0, 0, 8'hA5, 8'hA5, 0, 8, 1, 0));
    // clear, shift in 5A LSB first, update, view in test mode
    vecs.push_back(mk(0, 3'b100, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    for (int j = 1; j <= 8; j++) begin
      vecs.push_back(mk(0, 3'b010, 0, v5a[j-1], 8'hC3, 8'hC3, 0, 4'(j), (j == 8), 0));
    end
    vecs.push_back(mk(0, 3'b001, 1, 0, 8'hC3, 8'h5A, 0, 8, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 8'hC3, 8'hC3, 0, 8, 1, 0));
    // capture+shift conflict: capture wins, one-cycle error pulse
    vecs.push_back(mk(0, 3'b110, 0, 0, 8'hF0, 8'hF0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b000, 0, 0, 8'hF0, 8'hF0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 0, 8'h00, 8'hF0, 0, 0, 0, 0));
    // capture+update: update takes pre-edge F0, shift stage gets 11, error pulses
    vecs.push_back(mk(0, 3'b101, 1, 0, 8'h11, 8'hF0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 3'b000, 1, 0, 8'h11, 8'hF0, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].strb, vecs[i].m, vecs[i].t, vecs[i].pin);
      check($sformatf("vec%0d", i), vecs[i].e_po, vecs[i].e_tdo, vecs[i].e_cnt,
            vecs[i].e_full, vecs[i].e_err);
    end

    // reset in the middle of a shift discards everything
    drive(0, 3'b100, 0, 0, 8'hFF);
    drive(0, 3'b001, 1, 0, 8'h00);
    check("rst_pre_upd", 8'hFF, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) drive(0, 3'b010, 1, 1, 8'h00);
    check("rst_mid_shift", 8'hFF, 1, 4, 0, 0);
    drive(1, 3'b010, 1, 1, 8'h00);
    check("rst_applied", 8'h00, 0, 0, 0, 0);
    drive(0, 3'b001, 1, 0, 8'h00);
    check("rst_then_upd", 8'h00, 0, 0, 0, 0);
    drive(0, 3'b000, 0, 0, 8'h96);
    check("rst_func_mode", 8'h96, 0, 0, 0, 0);

    // update and shift on the same edge: update sees 81, chain becomes C0
    drive(0, 3'b100, 0, 0, 8'h81);
    check("us_capture", 8'h81, 1, 0, 0, 0);
    drive(0, 3'b011, 1, 1, 8'h00);
    check("us_same_edge", 8'h81, 0, 1, 0, 0);
    drive(0, 3'b001, 1, 0, 8'h00);
    check("us_chain_val", 8'hC0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_bs_chain_reg
